// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Address layout: tag = addr[15:9], index = addr[8:4], offset = addr[3:1].
// Also holds the miss-handler state enum and the address-split helper.
package dcache_pkg;

  localparam int LINES = 32;
  localparam int WORDS = 8;
  localparam int TAG_W = 7;
  localparam int IDX_W = 5;
  localparam int OFF_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;

  // Takes the half-word address (byte bit 0 already dropped).
  function automatic addr_t split_addr(input logic [15:1] a);
    addr_t r;
    r.tag = a[15:9];
    r.idx = a[8:4];
    r.off = a[3:1];
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Cache storage: per-line valid flops (async clear), tag and data arrays (no reset).
// Ports: combinational read of tag/valid/word; one word write per cycle; tag+valid install.
// Latency: reads 0 cycles, writes take effect at the next clock edge.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic [15:0]      rd_data_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic             rd_valid_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [15:0]      wr_data_i,
  input  logic             inst_en_i,
  input  logic [IDX_W-1:0] inst_idx_i,
  input  logic [TAG_W-1:0] inst_tag_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES][WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (inst_en_i) begin
      valid_q[inst_idx_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
    if (inst_en_i) begin
      tag_q[inst_idx_i] <= inst_tag_i;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache with an 8-word line refill FSM.
// Ports: pipeline side (addr/data_in/enable/wr -> data_out/stall), main memory side
// (mem_addr/mem_wdata/mem_enable/mem_wr -> mem_rdata/mem_rvalid). Read hit 0 cycles, write 1 cycle,
// read miss stalls until the refill lands (8 issue cycles + memory latency + 1).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        enable,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  // The controller never counts cycles; the latency only has to be sane.
  if (MEM_LAT < 1) begin : g_lat_chk
    $error("dcache_ctrl: MEM_LAT must be at least 1");
  end

  state_e           state_q, state_d;
  logic [3:0]       icnt_q, icnt_d;   // reads issued so far, 0..8
  logic [2:0]       rcnt_q, rcnt_d;   // responses received so far
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  addr_t            req;
  logic             unused_addr_lsb;
  logic [15:0]      arr_rdata;
  logic [TAG_W-1:0] arr_rtag;
  logic             arr_rvalid;
  logic             hit;
  logic             arr_we, arr_inst;
  logic [IDX_W-1:0] arr_widx;
  logic [OFF_W-1:0] arr_woff;
  logic [15:0]      arr_wdata;

  assign req             = split_addr(addr[15:1]);
  assign unused_addr_lsb = addr[0];
  assign hit             = arr_rvalid && (arr_rtag == req.tag);

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (req.idx),
    .rd_off_i   (req.off),
    .rd_data_o  (arr_rdata),
    .rd_tag_o   (arr_rtag),
    .rd_valid_o (arr_rvalid),
    .wr_en_i    (arr_we),
    .wr_idx_i   (arr_widx),
    .wr_off_i   (arr_woff),
    .wr_data_i  (arr_wdata),
    .inst_en_i  (arr_inst),
    .inst_idx_i (idx_q),
    .inst_tag_i (tag_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    icnt_d     = icnt_q;
    rcnt_d     = rcnt_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    stall      = 1'b0;
    data_out   = '0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    arr_we     = 1'b0;
    arr_inst   = 1'b0;
    arr_widx   = req.idx;
    arr_woff   = req.off;
    arr_wdata  = data_in;

    case (state_q)
      IDLE: begin
        if (enable && !wr) begin
          if (hit) begin
            data_out = arr_rdata;
          end else begin
            stall   = 1'b1;
            tag_d   = req.tag;
            idx_d   = req.idx;
            icnt_d  = '0;
            rcnt_d  = '0;
            state_d = FILL;
          end
        end else if (enable && wr) begin
          // Write-through: memory always sees the store; the line only if resident.
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = addr;
          mem_wdata  = data_in;
          arr_we     = hit;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (icnt_q < 4'd8) begin
          mem_enable = 1'b1;
          mem_addr   = {tag_q, idx_q, icnt_q[2:0], 1'b0};
          icnt_d     = icnt_q + 4'd1;
        end
        // Responses come back in issue order, so a separate counter places them.
        if (mem_rvalid) begin
          arr_we    = 1'b1;
          arr_widx  = idx_q;
          arr_woff  = rcnt_q;
          arr_wdata = mem_rdata;
          rcnt_d    = rcnt_q + 3'd1;
          if (rcnt_q == 3'd7) begin
            arr_inst = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is held the request may still look like a miss or a store;
    // keep the pipeline and memory quiet regardless.
    if (!rst) begin
      stall      = 1'b0;
      data_out   = '0;
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      arr_we     = 1'b0;
      arr_inst   = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_out;
  logic        stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .LINES   (32),
    .WORDS   (8),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .enable     (enable),
    .wr         (wr),
    .data_out   (data_out),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_enable (mem_enable),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // bmem is the environment's main memory (written by the DUT's stores);
  // ref_mem is what the bench believes memory holds (written from its own stimulus).
  logic [15:0] bmem    [32768];
  logic [15:0] ref_mem [32768];
  logic        mvalid  [32];
  logic [6:0]  mtag    [32];

  typedef struct {
    int          due;
    logic [15:0] d;
  } resp_t;
  resp_t       rq[$];
  logic [15:0] issued[$];

  function automatic logic [15:0] init_val(input int w);
    logic [31:0] x;
    x = w * 32'd40503;
    return x[15:0] ^ 16'h5A5A;
  endfunction

  // Pipelined main memory with fixed latency, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_enable && !mem_wr) begin
      rq.push_back('{cyc + MEM_LAT, bmem[mem_addr[15:1]]});
      issued.push_back(mem_addr);
    end else if (mem_enable && mem_wr) begin
      bmem[mem_addr[15:1]] = mem_wdata;
    end
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].d;
      void'(rq.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // {stall, mem_enable, mem_wr, mem_addr, mem_wdata, data_out}; address/data only when asked.
  function automatic logic [63:0] obs(input bit full);
    if (full) return {13'b0, stall, mem_enable, mem_wr, mem_addr, mem_wdata, data_out};
    return {13'b0, stall, mem_enable, mem_wr, 16'h0, 16'h0, data_out};
  endfunction

  function automatic logic [63:0] expv(input logic s, input logic me, input logic mw,
                                       input logic [15:0] ma, input logic [15:0] md,
                                       input logic [15:0] dout);
    return {13'b0, s, me, mw, ma, md, dout};
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    return mvalid[a[8:4]] && (mtag[a[8:4]] == a[15:9]);
  endfunction

  task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(negedge clk);
  endtask

  task automatic do_load_miss(input logic [15:0] a, input string nm);
    int n;
    int bad;
    logic [15:0] base;
    issued.delete();
    drive(1'b1, 1'b0, a, 16'h0);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, ":stall_cycles"}, 64'(n), 64'd13);
    chk({nm, ":data"}, obs(0), expv(0, 0, 0, 0, 0, ref_mem[a[15:1]]));
    base = {a[15:4], 4'h0};
    bad  = (issued.size() == 8) ? 0 : 1;
    for (int k = 0; k < issued.size() && k < 8; k++)
      if (issued[k] !== base + 16'(2 * k)) bad++;
    chk({nm, ":sweep"}, 64'(bad), 64'd0);
    mvalid[a[8:4]] = 1'b1;
    mtag[a[8:4]]   = a[15:9];
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d, input string nm);
    drive(1'b1, 1'b1, a, d);
    chk({nm, ":store"}, obs(1), expv(0, 1, 1, a, d, 0));
    ref_mem[a[15:1]] = d;
  endtask

  task automatic do_load(input logic [15:0] a, input string nm);
    if (model_hit(a)) begin
      drive(1'b1, 1'b0, a, 16'h0);
      chk({nm, ":hit"}, obs(0), expv(0, 0, 0, 0, 0, ref_mem[a[15:1]]));
    end else begin
      do_load_miss(a, nm);
    end
  endtask

  typedef struct {
    logic        en;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        e_stall;
    logic        e_men;
    logic        e_mwr;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int bad;
    for (int w = 0; w < 32768; w++) begin
      bmem[w]    = init_val(w);
      ref_mem[w] = init_val(w);
    end
    for (int i = 0; i < 32; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end

    // Reset held: a would-be miss and a would-be store are both silenced.
    drive(1'b1, 1'b0, 16'h1234, 16'h0);
    chk("reset:load", obs(0), expv(0, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b1, 16'h1234, 16'h5555);
    chk("reset:store", obs(0), expv(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    wr     = 1'b0;

    // Cold miss, then a hit in the same line.
    do_load_miss(16'h1234, "cold");
    chk("cold:model_hit_next", 64'(model_hit(16'h1236)), 64'd1);

    // Single-cycle behaviour on a resident line.
    tbl[0] = '{1'b1, 1'b0, 16'h1236, 16'h0000, 1'b0, 1'b0, 1'b0, init_val(16'h091B)};
    tbl[1] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF};
    tbl[3] = '{1'b0, 1'b1, 16'h1234, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 16'h123F, 16'h0000, 1'b0, 1'b0, 1'b0, init_val(16'h091F)};
    tbl[5] = '{1'b1, 1'b1, 16'h123E, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 16'h123E, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001};
    tbl[7] = '{1'b1, 1'b0, 16'h1230, 16'h0000, 1'b0, 1'b0, 1'b0, init_val(16'h0918)};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("table[%0d]", i), obs(tbl[i].e_men),
          expv(tbl[i].e_stall, tbl[i].e_men, tbl[i].e_mwr,
               tbl[i].e_men ? tbl[i].a : 16'h0, tbl[i].e_men ? tbl[i].d : 16'h0, tbl[i].e_dout));
      if (tbl[i].en && tbl[i].w) ref_mem[tbl[i].a[15:1]] = tbl[i].d;
    end

    // Store miss: memory only, then the load refills and sees it.
    do_store(16'h4000, 16'hBEEF, "wmiss");
    do_load_miss(16'h4000, "wmiss_load");

    // Conflict on index 1.
    do_load_miss(16'h0010, "conf_a");
    do_load_miss(16'h0210, "conf_b");
    do_load_miss(16'h0010, "conf_a2");

    // Reset in the middle of a refill.
    drive(1'b1, 1'b0, 16'h2468, 16'h0);
    chk("rstfill:miss", 64'(stall), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstfill:async", obs(0), expv(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    chk("rstfill:held", obs(0), expv(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    bad    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stall !== 1'b0 || mem_enable !== 1'b0 || data_out !== 16'h0) bad++;
    end
    chk("rstfill:stale_ignored", 64'(bad), 64'd0);
    do_load_miss(16'h2468, "rstfill_reload");
    do_load(16'h1234, "after_reset_cold");

    // Randomized mix over a small set of conflicting lines.
    for (int i = 0; i < 60; i++) begin
      int          op;
      logic [15:0] a;
      logic [15:0] d;
      op = $urandom_range(0, 2);
      a  = {7'(7'h10 + $urandom_range(0, 3)), 5'(8 + $urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      d  = 16'($urandom_range(0, 65535));
      case (op)
        0: begin
          drive(1'b0, 1'($urandom_range(0, 1)), a, d);
          chk($sformatf("rnd[%0d]:idle", i), obs(0), expv(0, 0, 0, 0, 0, 0));
        end
        1: do_store(a, d, $sformatf("rnd[%0d]", i));
        default: do_load(a, $sformatf("rnd[%0d]", i));
      endcase
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache with a miss-handling state machine, replacing the single-cycle data memory inside the memory stage. It accepts the stage's load/store request (ALU-computed address, store data, MemOp, MemWrite) and returns load data. On a read miss it holds the pipeline through `stall` while it refills an 8-word line from a multi-cycle, pipelined main memory.

## Interface
Parameters:
- LINES, 32, number of cache lines (index width = log2(LINES))
- WORDS, 8, 16-bit words per line (offset width = log2(WORDS))
- MEM_LAT, 4, main-memory read latency in cycles; used by the testbench only, the RTL is latency-agnostic

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- addr  in  16  byte address from the ALU; bit 0 ignored
- data_in  in  16  store data (RegData2)
- enable  in  1  memory operation this cycle (MemOp)
- wr  in  1  store when 1, load when 0 (MemWrite); ignored when enable=0
- data_out  out  16  load data
- stall  out  1  freeze upstream pipeline registers
- mem_addr  out  16  main-memory word address, byte-addressed
- mem_wdata  out  16  main-memory write data
- mem_enable  out  1  main-memory request valid
- mem_wr  out  1  main-memory request is a write
- mem_rdata  in  16  main-memory read data
- mem_rvalid  in  1  mem_rdata valid; one pulse per issued read, in order

## Operation
- Address split: offset = addr[3:1], index = addr[8:4], tag = addr[15:9] (7 bits).
- Hit: valid[index] && tag_array[index]==tag.
- FSM states:
  - IDLE
    - Read hit: data_out = word, stall=0.
    - Read miss: stall=1 combinationally; latch tag/index; go to FILL next edge.
    - Write: mem_enable=mem_wr=1, mem_addr=addr, mem_wdata=data_in, stall=0. On a hit, also update the cached word at the clock edge. On a miss, no allocation.
  - FILL
    - stall=1.
    - Issue counter k=0..7 issues one read per cycle, mem_addr={tag,index,k,1'b0}.
    - Receive counter writes each mem_rvalid word into data[index][rcnt].
    - On the 8th mem_rvalid: set tag, set valid[index], return to IDLE.
- data_out = 16'h0000 whenever not (IDLE && read hit).
- Upstream holds addr/enable/wr stable while stall=1. The request is re-evaluated in IDLE after the fill and hits.
- mem_rvalid in IDLE is ignored, including stale responses after a reset.
- enable=0: no memory request, stall=0, data_out=0.

## Timing
- Read hit: combinational, 0-cycle latency (matches the previous single-cycle memory).
- Write: 1 cycle, never stalls; memory write issued in the same cycle.
- Read miss detected at cycle T:
  - FILL covers T+1..T+8 issue.
  - With MEM_LAT=4, data arrives T+5..T+12.
  - IDLE at T+13, hit, stall=0, correct data_out.
  - Stall is high for 8+MEM_LAT+1 = 13 cycles.
- Reset (rst low, any state):
  - Immediately: state=IDLE, counters=0, all valid bits 0.
  - stall, mem_enable, mem_wr, data_out forced 0 while rst=0.
  - Data and tag arrays are not reset.
- Reset mid-FILL: the line stays invalid, and the same request misses again after reset.
- Write-hit data is visible to a read at the next cycle.

## Structure
- Package dcache_pkg:
  - LINES, WORDS, TAG_W=7, IDX_W=5, OFF_W=3
  - State enum {IDLE, FILL}
  - Field-extraction helpers
- Sub-module dcache_array:
  - Valid flops (async reset) and tag/data storage.
  - Read port: index/offset, combinational.
  - Write ports: one word per cycle, plus tag/valid install.
  - dcache_ctrl holds the FSM, counters, and memory-interface muxing.

## Test plan
- After reset, load 0x1234: stall is high 13 cycles; mem_addr sweeps 0x1230..0x123E; the word at 0x1234 is returned; the next load of 0x1236 hits, 0 stall.
- Store 0xBEEF to 0x1234 (line resident): mem_wr pulse with addr 0x1234 and data 0xBEEF, no stall; the next-cycle load returns 0xBEEF.
- Store to 0x4000 (not resident): memory write only; the following load of 0x4000 misses and refills, returning 0xBEEF-style data from memory.
- Conflict: load 0x0010 then 0x0210 (same index, tag 0 vs 1): both miss; reload 0x0010 misses again.
- Assert rst at T+6 of a fill: outputs go 0 immediately; late mem_rvalid pulses are ignored; the reissued load misses and completes correctly.
- enable=0 with wr=1 and random addr: no mem_enable, stall=0, data_out=0.
